// File: rtl/qam16_pkg.sv
// Shared types and constants for the QAM16 demapper frame sequencer.
package qam16_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } demap_state_t;

    localparam int NIB_W          = 4;
    localparam int BYTE_W         = 8;
    localparam int IQ_W           = 16;
    localparam int FIFO_DEPTH_DEF = 2;

    typedef struct packed {
        logic              last;
        logic [BYTE_W-1:0] data;
    } byte_entry_t;
endpackage

// File: rtl/qam16_demap_ctrl_if.sv
// Sample input stream and byte output stream of the QAM16 frame sequencer.
interface qam16_demap_ctrl_if;
    import qam16_pkg::*;

    // A beat transfers on a rising edge where valid && ready are both high;
    // the byte side holds tdata/tlast stable while valid && !ready.
    logic [IQ_W-1:0]   s_tdata;
    logic              s_tvalid;
    logic              s_tready;
    logic [BYTE_W-1:0] m_tdata;
    logic              m_tvalid;
    logic              m_tlast;
    logic              m_tready;

    // master: environment (sample source, byte sink); slave: the sequencer
    modport master (
        output s_tdata, s_tvalid, m_tready,
        input  s_tready, m_tdata, m_tvalid, m_tlast
    );
    modport slave (
        input  s_tdata, s_tvalid, m_tready,
        output s_tready, m_tdata, m_tvalid, m_tlast
    );
endinterface

// File: rtl/byte_fifo2.sv
// Two-entry byte FIFO with a registered head so the output stream comes straight from flops.
module byte_fifo2
    import qam16_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  byte_entry_t din,
    input  logic        pop,
    output byte_entry_t head,
    output logic [1:0]  count
);
    byte_entry_t tail;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head  <= din;
                        count <= 2'd1;
                    end else if (count == 2'd1) begin
                        tail  <= din;
                        count <= 2'd2;
                    end
                end
                2'b01: begin
                    if (count != 2'd0) begin
                        head  <= tail;
                        count <= count - 2'd1;
                    end
                end
                2'b11: begin
                    // count is unchanged; the new entry lands behind whatever remains
                    if (count == 2'd1) begin
                        head <= din;
                    end else begin
                        head <= tail;
                        tail <= din;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/qam16_demap_ctrl.sv
// Frame sequencer: feeds IQ samples to the external demapper, packs nibble pairs into bytes.
module qam16_demap_ctrl
    import qam16_pkg::*;
#(
    parameter int FRAME_LEN_W = 16,
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [FRAME_LEN_W-1:0] frame_len,
    output logic                   busy,
    output logic                   done,
    output logic [IQ_W-1:0]        demap_din,
    output logic                   demap_wren,
    input  logic                   demap_rdout,
    input  logic [NIB_W-1:0]       demap_dout,
    qam16_demap_ctrl_if.slave      io,
    output demap_state_t           dbg_state
);
    demap_state_t state, state_nxt;

    logic [FRAME_LEN_W-1:0] len, issued, received;
    logic                   half, inflight, done_q;
    logic [NIB_W-1:0]       hi_nib;
    logic [1:0]             fifo_count;
    byte_entry_t            fifo_head, push_entry;
    logic                   fifo_valid, pop, push, issue, last_issue;
    logic                   nib_take, rcv_last, last_pop, credit_ok, s_ready;
    logic [2:0]             reserved;

    assign fifo_valid = (fifo_count != 2'd0);
    assign pop        = fifo_valid && io.m_tready;
    assign issue      = io.s_tvalid && s_ready;
    assign last_issue = issue && (issued == len - FRAME_LEN_W'(1));

    // Slots already promised: stored bytes (minus one leaving now) plus one for a
    // half byte or in-flight symbol. The demapper cannot stall, so every result needs room.
    assign reserved  = {1'b0, fifo_count} - {2'b00, pop} + {2'b00, (inflight || half)};
    assign credit_ok = (reserved < 3'(FIFO_DEPTH));

    assign nib_take = demap_rdout && (state != IDLE) && (received != len);
    assign rcv_last = (received == len - FRAME_LEN_W'(1));
    assign push     = nib_take && (half || rcv_last);
    assign last_pop = (state == FLUSH) && pop && fifo_head.last;

    always_comb begin
        push_entry.last = rcv_last;
        push_entry.data = half ? {hi_nib, demap_dout} : {demap_dout, {NIB_W{1'b0}}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && (frame_len != '0)) state_nxt = RUN;
            RUN:     if (last_issue)                 state_nxt = FLUSH;
            FLUSH:   if (last_pop)                   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        s_ready = (state == RUN) && (issued < len) && credit_ok;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len      <= '0;
            issued   <= '0;
            received <= '0;
            half     <= 1'b0;
            hi_nib   <= '0;
            inflight <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            inflight <= issue;
            done_q   <= ((state == IDLE) && start && (frame_len == '0)) || last_pop;
            if ((state == IDLE) && start) begin
                len      <= frame_len;
                issued   <= '0;
                received <= '0;
                half     <= 1'b0;
            end else begin
                if (issue) issued <= issued + FRAME_LEN_W'(1);
                if (nib_take) begin
                    received <= received + FRAME_LEN_W'(1);
                    half     <= !half && !rcv_last;
                    if (!half) hi_nib <= demap_dout;
                end
            end
        end
    end

    byte_fifo2 u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .head  (fifo_head),
        .count (fifo_count)
    );

    assign io.s_tready = s_ready;
    assign io.m_tvalid = fifo_valid;
    assign io.m_tdata  = fifo_head.data;
    assign io.m_tlast  = fifo_head.last;
    assign demap_din   = io.s_tdata;
    assign demap_wren  = issue;
    assign done        = done_q;
    assign dbg_state   = state;
endmodule

// File: tb/tb_qam16_demap_ctrl.sv
// Bench for qam16_demap_ctrl: directed frames plus randomized frames against a frame-level model.
module tb_qam16_demap_ctrl;
    import qam16_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [15:0]  frame_len = 16'd0;
    logic         busy, done, demap_wren;
    logic [15:0]  demap_din;
    logic         demap_rdout = 1'b0;
    logic [3:0]   demap_dout = 4'd0;
    demap_state_t dbg_state;

    qam16_demap_ctrl_if io();

    qam16_demap_ctrl #(.FRAME_LEN_W(16), .FIFO_DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .frame_len   (frame_len),
        .busy        (busy),
        .done        (done),
        .demap_din   (demap_din),
        .demap_wren  (demap_wren),
        .demap_rdout (demap_rdout),
        .demap_dout  (demap_dout),
        .io          (io),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // External demapper stand-in: {re>=0, re inner, im<0, im inner}, one-cycle latency, no reset.
    function automatic logic [3:0] demap_nib(input logic [15:0] iq);
        int re, im;
        logic [3:0] n;
        re = int'($signed(iq[7:0]));
        im = int'($signed(iq[15:8]));
        n[3] = (re >= 0);
        n[2] = (re > -16) && (re < 16);
        n[1] = (im < 0);
        n[0] = (im > -16) && (im < 16);
        return n;
    endfunction

    always @(posedge clk) begin
        demap_rdout <= demap_wren;
        demap_dout  <= demap_nib(demap_din);
    end

    // ---------------- scoreboard state ----------------
    logic [15:0] send_q[$];
    logic [8:0]  exp_q[$];
    int          n_tests = 0, n_fail = 0;
    int          vpct = 100, rpct = 100;
    bit          start_val = 1'b0, inject = 1'b0;
    logic [15:0] len_val = 16'd0;
    int          cyc = 0, acc_cyc = 0, done_cyc = 0, done_cnt = 0, issued_cnt = 0, frame_done0 = 0;
    bit          seen_valid = 1'b0, busy_flag = 1'b0, prev_stall = 1'b0;
    logic [8:0]  prev_out = 9'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic observe();
        logic [8:0] e;
        cyc++;
        if (io.m_tvalid) seen_valid = 1'b1;
        if (prev_stall)
            check("hold", {23'd0, io.m_tvalid, io.m_tlast, io.m_tdata}, {23'd0, 1'b1, prev_out});
        prev_stall = io.m_tvalid && !io.m_tready;
        prev_out   = {io.m_tlast, io.m_tdata};
        if (io.m_tvalid && io.m_tready) begin
            if (exp_q.size() == 0) begin
                check("extra_byte", {23'd0, io.m_tlast, io.m_tdata}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("byte", {23'd0, io.m_tlast, io.m_tdata}, {23'd0, e});
                if (e[8]) acc_cyc = cyc;
            end
        end
        if (io.s_tvalid && io.s_tready && send_q.size() > 0) begin
            check("wren_din", {15'd0, demap_wren, demap_din}, {15'd0, 1'b1, send_q[0]});
            void'(send_q.pop_front());
            issued_cnt++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        busy_flag = busy && (exp_q.size() > 0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        start       = start_val || (inject && busy_flag && ($urandom_range(0, 9) == 0));
        frame_len   = start_val ? len_val : 16'($urandom_range(0, 20));
        io.s_tvalid = (send_q.size() > 0) && (int'($urandom_range(0, 99)) < vpct);
        io.s_tdata  = (send_q.size() > 0) ? send_q[0] : 16'($urandom);
        io.m_tready = int'($urandom_range(0, 99)) < rpct;
        #1;
        observe();
    endtask

    task automatic start_frame(input int len);
        issued_cnt  = 0;
        frame_done0 = done_cnt;
        start_val   = 1'b1;
        len_val     = 16'(len);
        tick();
        start_val   = 1'b0;
        check("start_busy_low", 32'(busy), 32'd0);
    endtask

    // Reference model: demap every sample, pair nibbles hi-first, pad an odd tail with 0.
    task automatic expect_from_send();
        logic [3:0] nibs[$];
        logic [3:0] lo;
        foreach (send_q[i]) nibs.push_back(demap_nib(send_q[i]));
        for (int i = 0; i < nibs.size(); i += 2) begin
            lo = (i + 1 < nibs.size()) ? nibs[i+1] : 4'h0;
            exp_q.push_back({(i + 2 >= nibs.size()), nibs[i], lo});
        end
    endtask

    task automatic load_random(input int len);
        for (int i = 0; i < len; i++) send_q.push_back(16'($urandom));
        expect_from_send();
    endtask

    task automatic wait_done(input int budget);
        bool_loop: for (int i = 0; i < budget && done_cnt == frame_done0; i++) tick();
        check("done_seen", 32'(done_cnt - frame_done0), 32'd1);
        check("exp_drained", 32'(exp_q.size()), 32'd0);
        check("done_latency", 32'(done_cyc - acc_cyc), 32'd1);
        repeat (3) tick();
        check("done_once", 32'(done_cnt - frame_done0), 32'd1);
        check("idle_after", {29'd0, busy, dbg_state}, {29'd0, 1'b0, IDLE});
        send_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_outputs();
        check("rst_s_tready", 32'(io.s_tready), 32'd0);
        check("rst_wren", 32'(demap_wren), 32'd0);
        check("rst_m_tvalid", 32'(io.m_tvalid), 32'd0);
        check("rst_m_tdata", 32'(io.m_tdata), 32'd0);
        check("rst_m_tlast", 32'(io.m_tlast), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        io.s_tvalid = 1'b0;
        io.s_tdata  = 16'd0;
        io.m_tready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;

        // Two symbols -> one byte 0x82 with last
        vpct = 100; rpct = 100;
        send_q = '{16'h2020, 16'hE0E0};
        exp_q.push_back({1'b1, 8'h82});
        start_frame(2);
        tick();
        check("first_issue", 32'(issued_cnt), 32'd1);
        wait_done(50);

        // Odd length -> padded final byte
        send_q = '{16'h2020, 16'h0404, 16'hE0E0};
        exp_q.push_back({1'b0, 8'h8D});
        exp_q.push_back({1'b1, 8'h20});
        start_frame(3);
        wait_done(50);

        // Ready tied high: one symbol per cycle
        load_random(8);
        start_frame(8);
        repeat (8) tick();
        check("no_bubble", 32'(issued_cnt), 32'd8);
        wait_done(50);

        // Backpressure: credit runs out after three symbols
        rpct = 0;
        load_random(8);
        start_frame(8);
        repeat (12) tick();
        check("bp_s_tready", 32'(io.s_tready), 32'd0);
        check("bp_issued", 32'(issued_cnt), 32'd3);
        check("bp_m_tvalid", 32'(io.m_tvalid), 32'd1);
        rpct = 100;
        wait_done(100);

        // Zero-length frame
        seen_valid = 1'b0;
        start_frame(0);
        tick();
        check("zero_done", 32'(done), 32'd1);
        check("zero_busy", 32'(busy), 32'd0);
        repeat (4) tick();
        check("zero_done_once", 32'(done_cnt - frame_done0), 32'd1);
        check("zero_no_valid", 32'(seen_valid), 32'd0);

        // Reset mid-frame with a demapper result still on its way
        rpct = 0;
        load_random(8);
        start_frame(8);
        for (int i = 0; i < 20 && issued_cnt < 3; i++) tick();
        check("pre_rst_issued", 32'(issued_cnt), 32'd3);
        @(posedge clk);
        #1 rst = 1'b1;
        #1 check_reset_outputs();
        #1 rst = 1'b0;
        send_q.delete();
        exp_q.delete();
        prev_stall = 1'b0;
        rpct = 100;
        send_q = '{16'h2020, 16'hE0E0};
        exp_q.push_back({1'b1, 8'h82});
        start_frame(2);
        wait_done(50);

        // Random frames, random valid/ready, spurious start while busy
        inject = 1'b1;
        for (int f = 0; f < 100; f++) begin
            int len;
            len  = int'($urandom_range(1, 12));
            vpct = int'($urandom_range(30, 100));
            rpct = int'($urandom_range(20, 100));
            load_random(len);
            start_frame(len);
            wait_done(400);
        end
        inject = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
